// File: rtl/instdecode_pkg.sv
// Shared constants for the instruction decoder: opcodes, ALU function codes,
// sequencer state encoding and instruction field positions.
package instdecode_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JNZ = 4'hC;
    localparam logic [3:0] OP_CMP = 4'hD;
    localparam logic [3:0] OP_RSV = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;
    localparam logic [2:0] ALU_LDI = 3'd6;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_ADV    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS_LSB  = 6;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/instdecode_fields.sv
// Purely combinational decode of the latched instruction register into
// field outputs, ALU function and instruction class flags.
module instdecode_fields
    import instdecode_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [2:0]  rd_addr,
    output logic [2:0]  rs_addr,
    output logic [7:0]  imm,
    output logic [5:0]  pc_target,
    output logic [2:0]  alu_op,
    output logic        is_alu,
    output logic        is_mem,
    output logic        is_br,
    output logic        writes_reg
);

    assign opcode    = ir[OPC_LSB +: 4];
    assign rd_addr   = ir[RD_LSB +: 3];
    assign rs_addr   = ir[RS_LSB +: 3];
    assign pc_target = ir[IMM_LSB +: 6];
    assign imm       = {2'b00, ir[IMM_LSB +: 6]};

    // CMP shares the subtractor but never writes back; opcode E falls to NOP here.
    always_comb begin
        alu_op     = ALU_ADD;
        is_alu     = 1'b0;
        is_mem     = 1'b0;
        is_br      = 1'b0;
        writes_reg = 1'b0;
        case (opcode)
            OP_ADD: begin alu_op = ALU_ADD; is_alu = 1'b1; writes_reg = 1'b1; end
            OP_SUB: begin alu_op = ALU_SUB; is_alu = 1'b1; writes_reg = 1'b1; end
            OP_AND: begin alu_op = ALU_AND; is_alu = 1'b1; writes_reg = 1'b1; end
            OP_OR:  begin alu_op = ALU_OR;  is_alu = 1'b1; writes_reg = 1'b1; end
            OP_XOR: begin alu_op = ALU_XOR; is_alu = 1'b1; writes_reg = 1'b1; end
            OP_MOV: begin alu_op = ALU_MOV; is_alu = 1'b1; writes_reg = 1'b1; end
            OP_LDI: begin alu_op = ALU_LDI; is_alu = 1'b1; writes_reg = 1'b1; end
            OP_CMP: begin alu_op = ALU_SUB; is_alu = 1'b1; end
            OP_LD:  begin is_mem = 1'b1; writes_reg = 1'b1; end
            OP_ST:  is_mem = 1'b1;
            OP_JMP, OP_JZ, OP_JNZ: is_br = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instdecode.sv
// Instruction register and FETCH/DECODE/EXEC/WB/ADV/HALT control sequencer.
// Optional illegal-opcode trap enabled by defining INSTDECODE_ILLEGAL_TRAP_EN.
module instdecode
    import instdecode_pkg::*;
#(
    parameter int INST_W       = 16,
    parameter int PC_W         = 6,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] instruction,
    input  logic              zero_flag,
    input  logic              mem_ready,
    output logic              inc_pc,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_target,
    output logic [INST_W-1:0] ir,
    output logic [2:0]        rd_addr,
    output logic [2:0]        rs_addr,
    output logic [7:0]        imm,
    output logic [2:0]        alu_op,
    output logic              alu_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              reg_we,
    output logic              halted,
    output logic              mem_err,
    output logic              illegal
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       opcode;
    logic             is_alu, is_mem, is_br, writes_reg;
    logic             mem_timeout, br_taken;

    instdecode_fields u_fields (
        .ir         (ir),
        .opcode     (opcode),
        .rd_addr    (rd_addr),
        .rs_addr    (rs_addr),
        .imm        (imm),
        .pc_target  (pc_target),
        .alu_op     (alu_op),
        .is_alu     (is_alu),
        .is_mem     (is_mem),
        .is_br      (is_br),
        .writes_reg (writes_reg)
    );

    // The last permitted wait cycle still carries the request; the abort lands on its edge.
    assign mem_timeout = (state == S_EXEC) && is_mem && !mem_ready &&
                         (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

    assign br_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JZ)  &&  zero_flag) ||
                      ((opcode == OP_JNZ) && !zero_flag);

    always_comb begin
        next_state = state;
        inc_pc     = 1'b0;
        pc_load    = 1'b0;
        alu_en     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_we     = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HLT)
                    next_state = S_HALT;
`ifdef INSTDECODE_ILLEGAL_TRAP_EN
                else if (opcode == OP_RSV)
                    next_state = S_HALT;
`endif
                else
                    next_state = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    alu_en     = 1'b1;
                    next_state = S_WB;
                end else if (is_mem) begin
                    mem_rd = (opcode == OP_LD);
                    mem_wr = (opcode == OP_ST);
                    if (mem_ready)
                        next_state = (opcode == OP_LD) ? S_WB : S_ADV;
                    else if (mem_timeout)
                        next_state = S_ADV;
                end else if (is_br) begin
                    pc_load    = br_taken;
                    next_state = br_taken ? S_FETCH : S_ADV;
                end else begin
                    next_state = S_ADV;
                end
            end
            S_WB: begin
                reg_we     = writes_reg;
                next_state = S_ADV;
            end
            S_ADV: begin
                inc_pc     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            default:  next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            ir       <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_FETCH)
                ir <= instruction;
            if ((state == S_EXEC) && is_mem && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (mem_timeout)
                mem_err <= 1'b1;
        end
    end

`ifdef INSTDECODE_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if ((state == S_DECODE) && (opcode == OP_RSV))
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/instdecode.md
Name: instdecode

Overview:
- Instruction-register and control sequencer directly downstream of instfetch.
- Latches the 16-bit instruction that instmem presents for the current PC and decodes it into register, ALU and memory control.
- Steps a FETCH/DECODE/EXEC/WB state machine for each instruction.
- Drives PC advance: a one-cycle inc_pc pulse, or a branch/jump load.

Parameters:
- INST_W, 16: instruction width.
- PC_W, 6: program-counter/address width; matches pc execadd.
- MEM_WAIT_MAX, 15: maximum EXEC cycles spent waiting for mem_ready before abort.

Ports:
- clk input 1: system clock; all logic on rising edge.
- reset input 1: synchronous, active-high reset.
- instruction input INST_W: from instmem; valid combinationally for the current PC.
- zero_flag input 1: ALU zero flag, sampled in EXEC.
- mem_ready input 1: data-memory completion for LD/ST.
- inc_pc output 1: one-cycle pulse; PC+1.
- pc_load output 1: one-cycle pulse; PC <= pc_target.
- pc_target output PC_W: branch/jump target, equal to ir[5:0].
- ir output INST_W: latched instruction register.
- rd_addr output 3: ir[11:9].
- rs_addr output 3: ir[8:6].
- imm output 8: ir[5:0] zero-extended.
- alu_op output 3: decoded ALU function.
- alu_en output 1: ALU operation strobe.
- mem_rd output 1: data-memory read request.
- mem_wr output 1: data-memory write request.
- reg_we output 1: register-file write enable.
- halted output 1: high while in HALT.
- mem_err output 1: sticky; set on memory timeout.
- illegal output 1: sticky; set on illegal opcode (only with the optional feature).

Behaviour:
- Reset (synchronous, active-high):
  - state = FETCH; ir = 0.
  - All strobes = 0: inc_pc, pc_load, alu_en, mem_rd, mem_wr, reg_we.
  - halted = 0, mem_err = 0, illegal = 0, wait counter = 0.
  - Reset in any state, including mid-memory-wait, aborts the instruction at the next edge.
- Opcode field ir[15:12]:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 MOV; 7 LDI.
  - 8 LD; 9 ST; A JMP; B JZ; C JNZ; D CMP; E reserved; F HLT.
- alu_op:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, MOV=5, LDI=6.
  - CMP=1 (SUB without write-back).
  - Otherwise 0.
- FETCH: ir <= instruction; next DECODE.
- DECODE:
  - Field outputs are valid from this cycle onward, combinational from ir.
  - HLT -> HALT; all other opcodes -> EXEC.
- EXEC:
  - ALU ops and CMP: alu_en=1 for one cycle; next WB.
  - LD: mem_rd held high until mem_ready; next WB.
  - ST: mem_wr held high until mem_ready; next ADV.
  - JMP: pc_load=1 for one cycle; next FETCH.
  - JZ: if zero_flag, pc_load=1 and next FETCH; else next ADV.
  - JNZ: as JZ with the zero_flag condition inverted.
  - NOP: next ADV.
- Memory wait:
  - Counter increments each EXEC cycle that mem_ready=0.
  - When the count reaches MEM_WAIT_MAX: drop the request, set mem_err, go to ADV (no reg_we).
  - mem_ready in the first EXEC cycle completes with zero wait.
- WB:
  - reg_we=1 for one cycle for ALU ops and LD.
  - CMP: reg_we=0.
  - Next ADV.
- ADV: inc_pc=1 for one cycle; next FETCH.
- Throughput: 5 cycles per ALU/LD instruction, 4 for NOP/ST/not-taken branch, 3 for taken branch/JMP. Memory ops add their wait cycles.
- inc_pc and pc_load are never high in the same cycle.
- HALT: halted=1, all strobes 0; only reset exits.
- PC wrap-around at 63->0 is owned by pc; not checked here.

Optional Feature:
- Macro: INSTDECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Opcode E in DECODE sets illegal (sticky) and enters HALT.
  - halted=1; no strobes issued.
- Undefined:
  - Opcode E decodes as NOP.
  - The illegal output is tied to 0.

Decomposition:
- Package instdecode_pkg:
  - Opcode localparams (OP_NOP..OP_HLT).
  - ALU function codes.
  - State encoding (FETCH, DECODE, EXEC, WB, ADV, HALT).
  - Field bit positions.
- One natural sub-module, instdecode_fields: combinational decode of ir into alu_op, class flags (is_alu, is_mem, is_br, writes_reg) and field outputs.
- The FSM and wait counter stay in instdecode.

Test Plan:
- ADD: reset, then instruction=16'h1280 (ADD r1,r2).
  - ir=1280 after FETCH; rd_addr=1, rs_addr=2, alu_op=0.
  - alu_en at cycle 3, reg_we at 4, inc_pc at 5, FETCH at 6.
- LD with wait: LD 16'h8005, mem_ready asserted after 3 cycles.
  - mem_rd high exactly 4 EXEC cycles, then reg_we, inc_pc.
  - mem_err=0.
- LD timeout: mem_ready held 0.
  - mem_rd drops after 15 cycles; mem_err=1; no reg_we; inc_pc follows.
- Conditional branches: JZ 16'hB02A with zero_flag=1, then zero_flag=0.
  - Taken: pc_load=1 with pc_target=6'h2A, no inc_pc.
  - Not taken: inc_pc only.
- HALT and reset recovery: HLT 16'hF000.
  - halted=1 and stays high for 20 cycles with no strobes.
  - Reset mid-HALT: halted=0 and state FETCH on the next edge.
- Opcode E: instruction 16'hE000.
  - With INSTDECODE_ILLEGAL_TRAP_EN: illegal=1, halted=1.
  - Without: behaves as NOP (inc_pc after 4 cycles), illegal=0.
